fluid_mailbox_reader: RTL and testbench
=======================================

Name: fluid_mailbox_reader

Overview:
- Consumer stage on port 2 of the shared 16384x16 NIOS/ARM on-chip RAM.
- Polls a producer-owned head pointer word and drains a 16-bit-word ring buffer out of that RAM.
- Delivers each word on a valid/ready stream to the fluid-board NIOS-side logic, then writes the updated tail pointer back to RAM so the producer can see free space.

Parameters:
- BASE_ADDR, 0, word address of ring entry 0
- RING_WORDS, 1024, ring length in 16-bit words; power of two, 2..8192
- HEAD_ADDR, 16382, word address of the producer head pointer (entry index)
- TAIL_ADDR, 16383, word address of the consumer tail pointer (entry index)
- POLL_CYCLES, 64, idle cycles between head polls when the ring is empty

Ports:
- clk  in  1  single clock, shared with the RAM
- reset  in  1  asynchronous, active-high
- enable  in  1  1 = run; 0 = finish the current word, then park in IDLE
- mem_address  out  14  RAM port-2 word address
- mem_chipselect  out  1  RAM port-2 chipselect
- mem_write  out  1  RAM port-2 write strobe
- mem_writedata  out  16  tail pointer writeback data
- mem_byteenable  out  2  always 2'b11
- mem_clken  out  1  always 1
- mem_readdata  in  16  RAM port-2 q; valid 1 cycle after address is presented
- out_data  out  16  ring word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accept
- tail  out  14  current local tail index
- err_head  out  1  sticky: head read >= RING_WORDS

Behaviour:
- Reset values: all mem_* strobes 0, mem_address 0, mem_writedata 0, out_valid 0, out_data 0, tail 0, err_head 0, FSM in IDLE, poll counter 0. Reset is asserted at any time and aborts any access immediately; an in-flight tail write is not completed.
- RAM timing: address and control registered by the RAM; mem_readdata is sampled exactly 1 cycle after a read cycle (chipselect=1, write=0). Each read is a single-cycle chipselect pulse.
- IDLE:
  - If enable=1 and poll counter is 0, go to RD_HEAD.
  - Otherwise decrement the counter, saturating at 0.
- RD_HEAD: drive HEAD_ADDR for 1 cycle -> WAIT_HEAD.
- WAIT_HEAD: capture head = mem_readdata[13:0].
  - If mem_readdata >= RING_WORDS (full 16-bit compare): set err_head, load poll counter with POLL_CYCLES-1 -> IDLE.
  - Else if head == tail: load poll counter -> IDLE.
  - Else -> RD_DATA.
- RD_DATA: drive BASE_ADDR+tail -> WAIT_DATA.
- WAIT_DATA: register out_data = mem_readdata and set out_valid=1 -> OUT.
- OUT: hold out_data/out_valid stable until out_valid & out_ready. On that cycle:
  - clear out_valid.
  - tail <= (tail+1) & (RING_WORDS-1), wrapping from RING_WORDS-1 to 0.
  - -> WR_TAIL.
- WR_TAIL: 1-cycle write of TAIL_ADDR with mem_writedata = {2'b0, new tail}.
  - If enable=1 and new tail != captured head: -> RD_DATA, draining without re-polling.
  - Else: -> RD_HEAD if enable=1, IDLE if enable=0 (poll counter 0).
- Latency: the first word appears 4 cycles after leaving IDLE (RD_HEAD, WAIT_HEAD, RD_DATA, WAIT_DATA). Sustained throughput is 1 word per 4 cycles with out_ready held high.
- Head captured once per burst: words the producer adds during a burst are picked up by the next RD_HEAD.
- enable deasserted in OUT: the word is still delivered and the tail written back, then -> IDLE.
- Full ring: the producer keeps one empty slot, so head == tail always means empty.
- err_head clears only on reset.

Optional Feature:
- Macro: FLUID_MAILBOX_STATS_EN.
- When defined:
  - adds output word_count (32 bits), incremented on every out_valid&out_ready handshake, wrapping at 2^32.
  - adds output poll_count (16 bits), incremented on every RD_HEAD entry, saturating at 16'hFFFF.
  - both reset to 0.
- When undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Empty ring: RAM head=0, tail=0, enable=1 -> no out_valid; RD_HEAD re-issued every POLL_CYCLES+2 cycles; no writes to TAIL_ADDR.
- Three words: RAM[0..2]=16'h1111/2222/3333, head=3, out_ready=1 -> those words in order; TAIL_ADDR written 1, 2, 3; first out_valid 4 cycles after RD_HEAD.
- Wrap: RING_WORDS=8, tail preloaded by draining to 6, head=1 -> entries 6, 7, 0 output; final tail=1 written.
- Backpressure: out_ready=0 for 20 cycles with one word pending -> out_valid and out_data stable all 20 cycles; no tail write until the handshake.
- Bad head: RAM head=16'h0400 with RING_WORDS=1024 -> err_head=1, no output, block keeps polling; set head=2 -> 2 words delivered, err_head stays 1.
- Reset mid-burst: assert reset in OUT -> out_valid=0 and tail=0 immediately; after release, re-polls from RD_HEAD with tail 0.

Source files
------------

// File: rtl/fluid_mailbox_reader_if.sv
// Port-2 RAM bus plus the outgoing word stream of the fluid mailbox reader.
// master = reader side, slave = RAM + sink side.
interface fluid_mailbox_reader_if;
  logic [13:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic        mem_clken;
  logic [15:0] mem_readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_writedata,
           mem_byteenable, mem_clken, out_data, out_valid,
    input  mem_readdata, out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_writedata,
           mem_byteenable, mem_clken, out_data, out_valid,
    output mem_readdata, out_ready
  );
endinterface

// File: rtl/fluid_mailbox_reader.sv
// Ring-buffer consumer on RAM port 2: polls the producer head, streams words out, writes tail back.
// Optional counters word_count/poll_count are built when FLUID_MAILBOX_STATS_EN is defined.
module fluid_mailbox_reader #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RING_WORDS  = 1024,
  parameter int unsigned HEAD_ADDR   = 16382,
  parameter int unsigned TAIL_ADDR   = 16383,
  parameter int unsigned POLL_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  fluid_mailbox_reader_if.master         bus,
  output logic [13:0]                    tail,
  output logic                           err_head
`ifdef FLUID_MAILBOX_STATS_EN
  ,
  output logic [31:0]                    word_count,
  output logic [15:0]                    poll_count
`endif
);

  localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [13:0]   MASK      = 14'(RING_WORDS - 1);
  localparam logic [13:0]   BASE_A    = 14'(BASE_ADDR);
  localparam logic [13:0]   HEAD_A    = 14'(HEAD_ADDR);
  localparam logic [13:0]   TAIL_A    = 14'(TAIL_ADDR);
  localparam logic [16:0]   RING_LIM  = 17'(RING_WORDS);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HEAD, S_WAIT_HEAD, S_RD_DATA, S_WAIT_DATA, S_OUT, S_WR_TAIL
  } state_e;

  state_e        state_q, state_d;
  logic [13:0]   tail_q, tail_d;
  logic [13:0]   head_q, head_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [13:0]   addr_c;
  logic          cs_c, we_c;
  logic [15:0]   wdata_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tail_q  <= '0;
      head_q  <= '0;
      poll_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      head_q  <= head_d;
      poll_q  <= poll_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // RAM strobes are decoded from state so reset drops them in the same instant.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    head_d  = head_q;
    poll_d  = poll_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    addr_c  = '0;
    cs_c    = 1'b0;
    we_c    = 1'b0;
    wdata_c = '0;
    case (state_q)
      S_IDLE: begin
        if (enable && poll_q == '0) state_d = S_RD_HEAD;
        else if (poll_q != '0)      poll_d  = poll_q - 1'b1;
      end
      S_RD_HEAD: begin
        cs_c    = 1'b1;
        addr_c  = HEAD_A;
        state_d = S_WAIT_HEAD;
      end
      S_WAIT_HEAD: begin
        head_d = bus.mem_readdata[13:0];
        // Upper bits count too: a head with bits above 13 set is corrupt, not aliased.
        if ({1'b0, bus.mem_readdata} >= RING_LIM) begin
          err_d   = 1'b1;
          poll_d  = POLL_LOAD;
          state_d = S_IDLE;
        end else if (bus.mem_readdata[13:0] == tail_q) begin
          poll_d  = POLL_LOAD;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        cs_c    = 1'b1;
        addr_c  = BASE_A + tail_q;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        data_d  = bus.mem_readdata;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          tail_d  = (tail_q + 14'd1) & MASK;
          state_d = S_WR_TAIL;
        end
      end
      S_WR_TAIL: begin
        cs_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = TAIL_A;
        wdata_c = {2'b00, tail_q};
        // Drain against the head captured at burst start; new entries wait for the next poll.
        if (enable && tail_q != head_q) begin
          state_d = S_RD_DATA;
        end else if (enable) begin
          state_d = S_RD_HEAD;
        end else begin
          poll_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_address    = addr_c;
  assign bus.mem_chipselect = cs_c;
  assign bus.mem_write      = we_c;
  assign bus.mem_writedata  = wdata_c;
  assign bus.mem_byteenable = 2'b11;
  assign bus.mem_clken      = 1'b1;
  assign bus.out_data       = data_q;
  assign bus.out_valid      = valid_q;
  assign tail               = tail_q;
  assign err_head           = err_q;

`ifdef FLUID_MAILBOX_STATS_EN
  logic [31:0] wcnt_q, wcnt_d;
  logic [15:0] pcnt_q, pcnt_d;

  // RD_HEAD always lasts exactly one cycle, so each cycle in it is one entry.
  always_comb begin
    wcnt_d = wcnt_q;
    pcnt_d = pcnt_q;
    if (valid_q && bus.out_ready)                   wcnt_d = wcnt_q + 32'd1;
    if (state_q == S_RD_HEAD && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      pcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign word_count = wcnt_q;
  assign poll_count = pcnt_q;
`endif

endmodule

// File: tb/tb_fluid_mailbox_reader.sv
// Bench for fluid_mailbox_reader: RAM model, event monitor, vector table, corner sequences, random producer.
module tb_fluid_mailbox_reader;
  localparam int RW     = 8;
  localparam int POLL   = 6;
  localparam int BASE   = 100;
  localparam int HEAD_A = 16382;
  localparam int TAIL_A = 16383;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [13:0] tail;
  logic        err_head;
`ifdef FLUID_MAILBOX_STATS_EN
  logic [31:0] word_count;
  logic [15:0] poll_count;
`endif

  fluid_mailbox_reader_if bus();

  fluid_mailbox_reader #(
    .BASE_ADDR(BASE), .RING_WORDS(RW), .HEAD_ADDR(HEAD_A),
    .TAIL_ADDR(TAIL_A), .POLL_CYCLES(POLL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .tail(tail), .err_head(err_head)
`ifdef FLUID_MAILBOX_STATS_EN
    , .word_count(word_count), .poll_count(poll_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: array owned by the stimulus process, tail word owned by the RAM write port.
  logic [15:0] ram [0:16383];
  logic [15:0] ram_tail = 16'h0;
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        if (bus.mem_address == 14'(TAIL_A)) ram_tail <= bus.mem_writedata;
      end else begin
        bus.mem_readdata <= (bus.mem_address == 14'(TAIL_A)) ? ram_tail : ram[bus.mem_address];
      end
    end
  end

  // Event monitor (sampled mid-cycle).
  logic [15:0] got_q[$];
  int          hs_t[$];
  logic [15:0] wr_q[$];
  int          poll_t[$];
  int          vrise_t[$];
  int          badwr = 0;
  logic        prev_v = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_chipselect && !bus.mem_write && bus.mem_address == 14'(HEAD_A)) poll_t.push_back(cyc);
      if (bus.mem_chipselect && bus.mem_write) begin
        if (bus.mem_address == 14'(TAIL_A)) wr_q.push_back(bus.mem_writedata);
        else badwr++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        hs_t.push_back(cyc);
      end
      if (bus.out_valid && !prev_v) vrise_t.push_back(cyc);
    end
    prev_v = bus.out_valid;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n, input int lim, input string nm);
    int k = 0;
    while (got_q.size() < n && k < lim) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(nm, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input int lim, input string nm);
    int k = 0;
    while (!bus.out_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  typedef struct {
    logic [15:0] head;
    int          start;
    int          n;
    int          etail;
    logic        eerr;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [15:0] pat(input int v, input int idx);
    return 16'(16'h5A00 + v * 16 + idx);
  endfunction

  logic [15:0] exp_q[$];

  initial begin
    int g0, w0, p0, v0, r0, lp, ph, inflight;
    logic [15:0] d;

    tbl[0] = '{16'd6,      3, 3, 6, 1'b0};
    tbl[1] = '{16'd1,      6, 3, 1, 1'b0};  // wraps 7 -> 0
    tbl[2] = '{16'd1,      1, 0, 1, 1'b0};  // empty
    tbl[3] = '{16'd0,      1, 7, 0, 1'b0};  // full ring less one slot
    tbl[4] = '{16'h0008,   0, 0, 0, 1'b1};  // head == RING_WORDS
    tbl[5] = '{16'd2,      0, 2, 2, 1'b1};  // err stays sticky

    for (int i = 0; i < 16384; i++) ram[i] = 16'h0;
    reset = 1'b1;
    enable = 1'b0;
    bus.out_ready = 1'b0;
    step(3);

    chk("rst_cs",    32'(bus.mem_chipselect), 0);
    chk("rst_we",    32'(bus.mem_write), 0);
    chk("rst_addr",  32'(bus.mem_address), 0);
    chk("rst_wdata", 32'(bus.mem_writedata), 0);
    chk("rst_be",    32'(bus.mem_byteenable), 3);
    chk("rst_clken", 32'(bus.mem_clken), 1);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data), 0);
    chk("rst_tail",  32'(tail), 0);
    chk("rst_err",   32'(err_head), 0);

    // Empty ring: periodic polls, nothing else.
    enable = 1'b1;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    r0 = cyc;
    step(45);
    chk("empty_polls", 32'(poll_t.size() >= 5), 1);
    if (poll_t.size() > 0) chk("empty_first_poll", 32'(poll_t[0]), 32'(r0 + 1));
    for (int i = 1; i < poll_t.size(); i++) chk("poll_period", 32'(poll_t[i] - poll_t[i-1]), POLL + 2);
    chk("empty_no_out", 32'(got_q.size()), 0);
    chk("empty_no_wr",  32'(wr_q.size()), 0);

    // Three words, latency and throughput.
    g0 = got_q.size(); w0 = wr_q.size(); v0 = vrise_t.size();
    ram[BASE+0] = 16'h1111; ram[BASE+1] = 16'h2222; ram[BASE+2] = 16'h3333;
    ram[HEAD_A] = 16'd3;
    wait_got(g0 + 3, 100, "three_done");
    step(6);
    if (got_q.size() >= g0 + 3) begin
      chk("three_w0", 32'(got_q[g0]),   32'h1111);
      chk("three_w1", 32'(got_q[g0+1]), 32'h2222);
      chk("three_w2", 32'(got_q[g0+2]), 32'h3333);
      chk("three_gap1", 32'(hs_t[g0+1] - hs_t[g0]), 4);
      chk("three_gap2", 32'(hs_t[g0+2] - hs_t[g0+1]), 4);
    end
    chk("three_nwr", 32'(wr_q.size() - w0), 3);
    for (int i = 0; i < 3 && w0 + i < wr_q.size(); i++) chk("three_wr", 32'(wr_q[w0+i]), 32'(i + 1));
    if (vrise_t.size() > v0) begin
      lp = -1000;
      foreach (poll_t[i]) if (poll_t[i] <= vrise_t[v0]) lp = poll_t[i];
      chk("three_latency", 32'(vrise_t[v0] - lp), 4);
    end else chk("three_vrise", 32'(vrise_t.size()), 32'(v0 + 1));

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      chk("tv_start_tail", 32'(tail), 32'(tbl[v].start));
      for (int i = 0; i < RW; i++) ram[BASE+i] = pat(v, i);
      g0 = got_q.size(); w0 = wr_q.size(); p0 = poll_t.size();
      ram[HEAD_A] = tbl[v].head;
      if (tbl[v].n > 0) wait_got(g0 + tbl[v].n, 200, "tv_done");
      step(30);
      chk("tv_nout", 32'(got_q.size() - g0), 32'(tbl[v].n));
      for (int k = 0; k < tbl[v].n && g0 + k < got_q.size(); k++)
        chk("tv_data", 32'(got_q[g0+k]), 32'(pat(v, (tbl[v].start + k) % RW)));
      chk("tv_nwr", 32'(wr_q.size() - w0), 32'(tbl[v].n));
      for (int k = 0; k < tbl[v].n && w0 + k < wr_q.size(); k++)
        chk("tv_wr", 32'(wr_q[w0+k]), 32'((tbl[v].start + k + 1) % RW));
      chk("tv_tail", 32'(tail), 32'(tbl[v].etail));
      chk("tv_err", 32'(err_head), 32'(tbl[v].eerr));
      chk("tv_repoll", 32'(poll_t.size() - p0 >= 2), 1);
    end

    // Backpressure: tail = 2, one word pending.
    bus.out_ready = 1'b0;
    ram[BASE+2] = 16'hBEEF;
    g0 = got_q.size();
    ram[HEAD_A] = 16'd3;
    wait_valid(60, "bp_valid_seen");
    w0 = wr_q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(bus.out_valid), 1);
      chk("bp_data_hold",  32'(bus.out_data), 32'hBEEF);
      chk("bp_no_wr",      32'(wr_q.size()), 32'(w0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    step(4);
    chk("bp_nwr", 32'(wr_q.size()), 32'(w0 + 1));
    if (wr_q.size() > w0) chk("bp_wr", 32'(wr_q[w0]), 3);
    chk("bp_nout", 32'(got_q.size()), 32'(g0 + 1));
    if (got_q.size() > g0) chk("bp_out", 32'(got_q[g0]), 32'hBEEF);
    step(20);

    // Reset while a word is held in OUT.
    bus.out_ready = 1'b0;
    ram[BASE+3] = 16'h7777;
    ram[HEAD_A] = 16'd4;
    wait_valid(60, "rm_valid_seen");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rm_valid", 32'(bus.out_valid), 0);
    chk("rm_tail",  32'(tail), 0);
    chk("rm_cs",    32'(bus.mem_chipselect), 0);
    ram[BASE+0] = 16'hA0A0; ram[BASE+1] = 16'hA1A1;
    ram[HEAD_A] = 16'd2;
    bus.out_ready = 1'b1;
    step(2);
    chk("rm_err_cleared", 32'(err_head), 0);
    g0 = got_q.size(); w0 = wr_q.size(); p0 = poll_t.size();
    reset = 1'b0;
    r0 = cyc;
    wait_got(g0 + 2, 100, "rm_done");
    step(6);
    if (poll_t.size() > p0) chk("rm_first_poll", 32'(poll_t[p0]), 32'(r0 + 1));
    if (got_q.size() >= g0 + 2) begin
      chk("rm_w0", 32'(got_q[g0]),   32'hA0A0);
      chk("rm_w1", 32'(got_q[g0+1]), 32'hA1A1);
    end
    chk("rm_nwr", 32'(wr_q.size() - w0), 2);
    if (wr_q.size() >= w0 + 2) begin
      chk("rm_wr0", 32'(wr_q[w0]),   1);
      chk("rm_wr1", 32'(wr_q[w0+1]), 2);
    end

    // Random producer, random sink stalls and enable toggles against a FIFO model.
    reset = 1'b1;
    ram[HEAD_A] = 16'd0;
    step(2);
    g0 = got_q.size(); w0 = wr_q.size();
    ph = 0;
    reset = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 9) != 0);
      // Slots are free once the consumer has published its tail.
      inflight = exp_q.size() - (wr_q.size() - w0);
      if ($urandom_range(0, 2) == 0 && inflight < RW - 1) begin
        d = 16'($urandom);
        ram[BASE+ph] = d;
        exp_q.push_back(d);
        ph = (ph + 1) % RW;
        ram[HEAD_A] = 16'(ph);
      end
    end
    enable = 1'b1;
    bus.out_ready = 1'b1;
    wait_got(g0 + exp_q.size(), 400, "rnd_drain");
    step(8);
    chk("rnd_nout", 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
      chk("rnd_data", 32'(got_q[g0+i]), 32'(exp_q[i]));
    chk("rnd_nwr", 32'(wr_q.size() - w0), 32'(exp_q.size()));
    for (int i = 0; w0 + i < wr_q.size(); i++)
      chk("rnd_wr", 32'(wr_q[w0+i]), 32'((i + 1) % RW));
    chk("rnd_tail", 32'(tail), 32'(exp_q.size() % RW));
    chk("rnd_err",  32'(err_head), 0);
    chk("bad_writes", 32'(badwr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
